// File: rtl/timer_unit_pkg.sv
// Shared types and constants for the timer unit: FSM states, TAC tap-select
// encoding and the register offsets inside the FF04-FF07 window.
package timer_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_OVF    = 2'b01,
      ST_RELOAD = 2'b10
   } timer_state_e;

   typedef enum logic [1:0] {
      TAC_SEL_4096   = 2'b00,
      TAC_SEL_262144 = 2'b01,
      TAC_SEL_65536  = 2'b10,
      TAC_SEL_16384  = 2'b11
   } tac_sel_e;

   // Register offsets, decoded from {a1, a0}; offset 0 (FF04 DIV) lives elsewhere.
   localparam logic [1:0] OFS_TIMA = 2'd1;
   localparam logic [1:0] OFS_TMA  = 2'd2;
   localparam logic [1:0] OFS_TAC  = 2'd3;

   // Unimplemented upper TAC bits read back as ones.
   localparam logic [4:0] TAC_READ_PAD = 5'b11111;

endpackage : timer_unit_pkg

// File: rtl/timer_unit_tick_sel.sv
// Tick generator: picks one divider tap, gates it with the timer enable and
// emits a one-cycle tick on every falling edge of the gated source. Edges
// created by reprogramming TAC or by the divider being cleared count too.
module timer_tick_sel
   import timer_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       div_4096hz_i,
   input  logic       div_262144hz_i,
   input  logic       div_65536hz_i,
   input  logic       div_16384hz_i,
   input  logic       tac_en_i,
   input  logic [1:0] tac_sel_i,
   output logic       tick_o
);

   logic tap_sel;
   logic tick_src;
   logic tick_prev_q;

   // Tap multiplexer driven by the TAC select field.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      tap_sel = 1'b0;
      case (tac_sel_e'(tac_sel_i))
         TAC_SEL_4096:   tap_sel = div_4096hz_i;
         TAC_SEL_262144: tap_sel = div_262144hz_i;
         TAC_SEL_65536:  tap_sel = div_65536hz_i;
         TAC_SEL_16384:  tap_sel = div_16384hz_i;
      endcase
   end

   // Disabling the timer forces the source low, which itself is a falling edge.
   assign tick_src = tap_sel & tac_en_i;

   // Remember last cycle's source level for falling-edge detection.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) tick_prev_q <= 1'b0;
      else       tick_prev_q <= tick_src;
   end

   assign tick_o = tick_prev_q & ~tick_src;

endmodule : timer_tick_sel

// File: rtl/timer_unit.sv
// Programmable timer (TIMA/TMA/TAC). TIMA counts divider ticks; on wrap it
// reads 00 for one cycle (OVF), is reloaded from TMA, and the interrupt
// fires during the following cycle (RELOAD). CPU writes can cancel or
// override the reload as the FSM below describes.
module timer_unit
   import timer_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ff04_ff07,
   input  logic       a0,
   input  logic       a1,
   input  logic       cpu_wr,
   input  logic       cpu_rd,
   inout  wire  [7:0] d,
   input  logic       div_4096hz,
   input  logic       div_262144hz,
   input  logic       div_65536hz,
   input  logic       div_16384hz,
   output logic       int_timer
);

   timer_state_e state_q;
   logic [7:0]   tima_q;
   logic [7:0]   tma_q;
   logic [2:0]   tac_q;
   logic         int_timer_q;

   logic [1:0]   addr;
   logic         wr_tima;
   logic         wr_tma;
   logic         wr_tac;
   logic         rd_en;
   logic [7:0]   rd_data;
   logic         tick;

   assign addr    = {a1, a0};
   assign wr_tima = cpu_wr & ff04_ff07 & (addr == OFS_TIMA);
   assign wr_tma  = cpu_wr & ff04_ff07 & (addr == OFS_TMA);
   assign wr_tac  = cpu_wr & ff04_ff07 & (addr == OFS_TAC);
   // FF04 belongs to the divider block; the bus also stays released in reset.
   assign rd_en   = cpu_rd & ff04_ff07 & (addr != 2'd0) & ~reset;

   timer_tick_sel u_tick_sel (
      .clk            (clk),
      .reset          (reset),
      .div_4096hz_i   (div_4096hz),
      .div_262144hz_i (div_262144hz),
      .div_65536hz_i  (div_65536hz),
      .div_16384hz_i  (div_16384hz),
      .tac_en_i       (tac_q[2]),
      .tac_sel_i      (tac_q[1:0]),
      .tick_o         (tick)
   );

   // Counter FSM with TIMA/TMA/TAC registers and the registered interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         tima_q      <= 8'h00;
         tma_q       <= 8'h00;
         tac_q       <= 3'b000;
         int_timer_q <= 1'b0;
      end else begin
         int_timer_q <= 1'b0;
         if (wr_tma) tma_q <= d;
         if (wr_tac) tac_q <= d[2:0];
         case (state_q)
            ST_RUN: begin
               // A CPU write to TIMA wins over a coincident tick.
               if (wr_tima) begin
                  tima_q <= d;
               end else if (tick) begin
                  tima_q <= tima_q + 8'd1;
                  if (tima_q == 8'hFF) state_q <= ST_OVF;
               end
            end
            ST_OVF: begin
               // Writing TIMA here cancels the reload and the interrupt.
               if (wr_tima) begin
                  tima_q  <= d;
                  state_q <= ST_RUN;
               end else begin
                  tima_q      <= tma_q;
                  state_q     <= ST_RELOAD;
                  int_timer_q <= 1'b1;
               end
            end
            ST_RELOAD: begin
               // TIMA is locked to TMA this cycle; a TMA write passes through.
               if (wr_tma) tima_q <= d;
               state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // Read-back multiplexer for the shared data bus.
   always_comb begin
      rd_data = 8'h00;
      case (addr)
         OFS_TIMA: rd_data = tima_q;
         OFS_TMA:  rd_data = tma_q;
         OFS_TAC:  rd_data = {TAC_READ_PAD, tac_q};
         default:  rd_data = 8'h00;
      endcase
   end

   assign d         = rd_en ? rd_data : 8'bzzzz_zzzz;
   assign int_timer = int_timer_q;

endmodule : timer_unit

// File: doc/timer_unit.md
TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 clk  in  1  system clock, one cycle per M-cycle (1.048576 MHz); all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ff04_ff07  in  1  decoded address window FF04-FF07.
REQ-004 a0, a1  in  1 each  low address bits; 01=FF05 TIMA, 10=FF06 TMA, 11=FF07 TAC, 00=FF04 ignored here.
REQ-005 cpu_wr, cpu_rd  in  1 each  write/read strobes, levels sampled at clk.
REQ-006 d  inout  8  shared data bus; driven only during a matching read, else high-Z.
REQ-007 div_4096hz, div_262144hz, div_65536hz, div_16384hz  in  1 each  divider tap levels from clocks_reset.
REQ-008 int_timer  out  1  timer interrupt request pulse to the interrupt controller.

Function
REQ-009 Registers: TIMA[7:0], TMA[7:0], TAC[2:0]; TAC[1:0] selects tap, TAC[2] enables.
REQ-010 Tap select: 00->div_4096hz, 01->div_262144hz, 10->div_65536hz, 11->div_16384hz.
REQ-011 tick_src = selected tap AND TAC[2]; tick_prev registered each clk.
REQ-012 Tick SHALL occur in the cycle where tick_prev=1 and tick_src=0, i.e. one per falling edge.
REQ-013 Falling edges from TAC writes (enable cleared, select changed) or from DIV reset forcing a tap low SHALL count as ticks.
REQ-014 FSM states: RUN, OVF, RELOAD; reset state RUN.
REQ-015 RUN: tick with TIMA<FF -> TIMA+1; tick with TIMA=FF -> TIMA=00, next state OVF.
REQ-016 OVF (one cycle): TIMA reads 00; next state RELOAD, TIMA<=TMA.
REQ-017 RELOAD (one cycle): int_timer=1 for exactly this cycle; next state RUN.
REQ-018 Ticks arriving in OVF or RELOAD cycles SHALL be discarded.
REQ-019 Write TIMA in RUN: TIMA<=d; a coincident tick is discarded.
REQ-020 Write TIMA in OVF: TIMA<=d, next state RUN, no reload, no int_timer.
REQ-021 Write TIMA in RELOAD: ignored; TIMA keeps TMA value.
REQ-022 Write TMA in any state: TMA<=d; in RELOAD also TIMA<=d.
REQ-023 Write TAC: TAC<=d[2:0]; d[7:3] discarded.
REQ-024 Read (cpu_rd & ff04_ff07 & addr match) SHALL drive combinationally: TIMA, TMA, or {5'b11111, TAC}; FF04 never driven.
REQ-025 Arithmetic is 8-bit modulo; no saturation.

Reset
REQ-026 reset SHALL set TIMA=00, TMA=00, TAC=000, tick_prev=0, state RUN, int_timer=0, d high-Z, in the cycle it is sampled.
REQ-027 reset in OVF or RELOAD SHALL abort the pending reload/interrupt; no int_timer pulse follows.
REQ-028 reset has priority over any coincident write or tick.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the TAC select encoding, and register offset constants (TIMA=1, TMA=2, TAC=3).
REQ-030 One sub-module timer_tick_sel SHALL contain tap mux, enable gating, and falling-edge detector, output tick.
REQ-031 No other sub-modules; FSM and registers live in timer_unit.

Verification
REQ-032 TAC=101, TIMA=FE, TMA=40, toggle div_262144hz twice -> TIMA FF, 00 (OVF cycle), then 40 with int_timer=1 for one cycle.
REQ-033 Overflow then write TIMA=12 in OVF cycle -> TIMA=12, no int_timer, state RUN.
REQ-034 Overflow, in RELOAD cycle write TIMA=55 and TMA=77 together -> TIMA=77, TMA=77, int_timer pulse present.
REQ-035 TAC=100, div_4096hz high, write TAC=000 -> TIMA increments by 1 (disable edge).
REQ-036 Assert reset during OVF -> TIMA=00, TMA=00, TAC=000, no int_timer in following cycles.
REQ-037 Read FF07 with TAC=010 -> d=FA; read with cpu_rd=0 -> d high-Z.
